// File: rtl/shift_reg_pkg.sv
// Shared definitions for the PISO/SIPO shifter pair: FSM states, default width,
// and the bit-counter width helper.
package shift_reg_pkg;

   typedef enum logic {ST_COLLECT, ST_PARITY} deser_state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Counter must hold the values 0..width, hence width+1.
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/out_hold_reg.sv
// One-entry output holding register with valid/ready handshake; reports a drop
// pulse when a word arrives while the held word is still unconsumed.
module out_hold_reg
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_flag,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_flag,
   output logic             drop
);

   // Handshake: a word is consumed on any cycle with out_valid && out_ready;
   // out_data/out_flag stay stable while out_valid && !out_ready, and a word
   // may be accepted and a new one loaded on the same edge.
   logic free;

   assign free = !out_valid || out_ready;
   assign drop = load && !free;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_flag  <= 1'b0;
      end else if (load && free) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
         out_flag  <= load_flag;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/sipo_deserializer.sv
// MSB-first serial-to-parallel deserializer with one-entry output register and
// sticky overflow. Optional even-parity frame check under `PARITY_CHECK_EN.
module sipo_deserializer
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shift_en,
   input  logic             serial_in,
   input  logic             sync,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             overflow,
   input  logic             ovf_clr,
   output logic             par_err,
   output deser_state_t     state_dbg
);

   localparam int              CNT_W    = cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   deser_state_t     state, state_nxt;
   logic [WIDTH-1:0] shift_reg;
   logic [CNT_W-1:0] bit_cnt;
   logic             data_bit;
   logic             load;
   logic [WIDTH-1:0] load_word;
   logic             load_flag;
   logic             drop;
`ifdef PARITY_CHECK_EN
   logic             par_acc;
`endif

   always_comb begin
      state_nxt = state;
      data_bit  = 1'b0;
      load      = 1'b0;
      load_word = {shift_reg[WIDTH-2:0], serial_in};
      load_flag = 1'b0;
      if (sync) begin
         state_nxt = ST_COLLECT;
      end else if (shift_en) begin
         case (state)
            ST_COLLECT: begin
               data_bit = 1'b1;
               if (bit_cnt == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
                  state_nxt = ST_PARITY;
`else
                  load = 1'b1;
`endif
               end
            end
`ifdef PARITY_CHECK_EN
            // Full word already sits in shift_reg; this cycle carries the parity bit.
            ST_PARITY: begin
               state_nxt = ST_COLLECT;
               load      = 1'b1;
               load_word = shift_reg;
               load_flag = par_acc ^ serial_in;
            end
`endif
            default: state_nxt = ST_COLLECT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_COLLECT;
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (sync) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
         end else if (data_bit) begin
            shift_reg <= {shift_reg[WIDTH-2:0], serial_in};
            bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
         end
      end
   end

`ifdef PARITY_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               par_acc <= 1'b0;
      else if (sync || load)    par_acc <= 1'b0;
      else if (data_bit)        par_acc <= par_acc ^ serial_in;
   end
`endif

   // Drop beats clear when both happen in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
   end

   out_hold_reg #(.WIDTH(WIDTH)) u_hold (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_data (load_word),
      .load_flag (load_flag),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_flag  (par_err),
      .drop      (drop)
   );

   assign state_dbg = state;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: inputs change on the falling edge,
// outputs are checked on the falling edge after each rising edge.
module tb_sipo_deserializer;
   import shift_reg_pkg::*;

   localparam int W = 8;
`ifdef PARITY_CHECK_EN
   localparam int FRAME = W + 1;
`else
   localparam int FRAME = W;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         shift_en = 1'b0;
   logic         serial_in = 1'b0;
   logic         sync = 1'b0;
   logic         out_ready = 1'b0;
   logic         ovf_clr = 1'b0;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         overflow;
   logic         par_err;
   deser_state_t state_dbg;

   int n_tests = 0;
   int n_fail  = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_w;
   logic [FRAME-1:0] frame;

   sipo_deserializer #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .shift_en  (shift_en),
      .serial_in (serial_in),
      .sync      (sync),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr),
      .par_err   (par_err),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Frame bits MSB-first; with parity enabled an even-parity bit follows (bad=1 flips it).
   function automatic logic [FRAME-1:0] build_frame(input logic [W-1:0] w, input logic bad);
`ifdef PARITY_CHECK_EN
      return {w, (^w) ^ bad};
`else
      return w;
`endif
   endfunction

   task automatic send_bit(input logic b);
      shift_en  = 1'b1;
      serial_in = b;
      @(negedge clk);
      shift_en  = 1'b0;
   endtask

   task automatic send_word(input logic [W-1:0] w, input logic bad);
      logic [FRAME-1:0] f;
      f = build_frame(w, bad);
      for (int i = FRAME - 1; i >= 0; i--) send_bit(f[i]);
   endtask

   task automatic expect_word(input string tag);
      exp_w = exp_q.pop_front();
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_data"}, 32'(out_data), 32'(exp_w));
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_par", 32'(par_err), 32'd0);
      check("rst_state", 32'(state_dbg), 32'(ST_COLLECT));
      rst_n = 1'b1;
      @(negedge clk);

      // 1: continuous 8'hCC, valid one clock after the last bit
      out_ready = 1'b1;
      exp_q.push_back(8'hCC);
      send_word(8'hCC, 1'b0);
      expect_word("t1");
      check("t1_ovf", 32'(overflow), 32'd0);
      @(negedge clk);
      check("t1_consumed", 32'(out_valid), 32'd0);

      // 2: 8'hD0 with shift_en toggling every cycle
      frame = build_frame(8'hD0, 1'b0);
      exp_q.push_back(8'hD0);
      for (int i = FRAME - 1; i >= 0; i--) begin
         send_bit(frame[i]);
         if (i > 0) check("t2_early_valid", 32'(out_valid), 32'd0);
         else       expect_word("t2");
         @(negedge clk);
      end
      check("t2_dequeued", 32'(out_valid), 32'd0);
      check("t2_data_kept", 32'(out_data), 32'hD0);

      // 3: consumer stalled; second word is dropped
      out_ready = 1'b0;
      exp_q.push_back(8'hA5);
      send_word(8'hA5, 1'b0);
      expect_word("t3a");
      exp_q.push_back(8'hA5);
      send_word(8'h3C, 1'b0);
      expect_word("t3b");
      check("t3_ovf_set", 32'(overflow), 32'd1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      check("t3_ovf_clr", 32'(overflow), 32'd0);
      check("t3_still_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      check("t3_consumed", 32'(out_valid), 32'd0);

      // 4: partial word, then sync with shift_en high, then 8'h81
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      sync = 1'b1;
      send_bit(1'b1);
      sync = 1'b0;
      check("t4_no_valid", 32'(out_valid), 32'd0);
      exp_q.push_back(8'h81);
      send_word(8'h81, 1'b0);
      expect_word("t4");
      @(negedge clk);

      // 5: accept and reload on the same edge
      out_ready = 1'b0;
      exp_q.push_back(8'h11);
      send_word(8'h11, 1'b0);
      expect_word("t5a");
      frame = build_frame(8'h22, 1'b0);
      exp_q.push_back(8'h22);
      for (int i = FRAME - 1; i >= 0; i--) begin
         out_ready = (i == 0);
         send_bit(frame[i]);
      end
      out_ready = 1'b0;
      expect_word("t5b");
      check("t5_ovf", 32'(overflow), 32'd0);

      // 6: asynchronous reset mid-word while a word is held
      frame = build_frame(8'hF0, 1'b0);
      for (int i = FRAME - 1; i >= FRAME - 5; i--) send_bit(frame[i]);
      check("t6_held", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_valid", 32'(out_valid), 32'd0);
      check("t6_async_data", 32'(out_data), 32'd0);
      check("t6_async_ovf", 32'(overflow), 32'd0);
      check("t6_async_par", 32'(par_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      exp_q.push_back(8'hF0);
      send_word(8'hF0, 1'b0);
      expect_word("t6");
      check("t6_ovf", 32'(overflow), 32'd0);
`ifdef PARITY_CHECK_EN
      check("t6_par_good", 32'(par_err), 32'd0);
      exp_q.push_back(8'hF0);
      send_word(8'hF0, 1'b1);
      expect_word("t6_bad");
      check("t6_par_bad", 32'(par_err), 32'd1);
`endif
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
